// File: rtl/uart_p_pkg.sv
// Shared definitions for the uart_xcvr_p transceiver: parity modes, FSM state
// encodings, the baud-rate table and the rounded divisor helper.
package uart_p_pkg;

  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;

  typedef enum logic [2:0] {
    TxIdle, TxStart, TxData, TxParity, TxStop1, TxStop2
  } tx_state_e;

  typedef enum logic [2:0] {
    RxIdle, RxStart, RxData, RxParity, RxStop1, RxStop2, RxBreak
  } rx_state_e;

  localparam int unsigned BAUD_TABLE [8] = '{300, 1200, 4800, 9600, 19200, 38400, 57600, 115200};

  // Clock cycles per sample tick, rounded to nearest, never below 1.
  function automatic int unsigned div(input int unsigned clk_hz, input int unsigned baud,
                                      input int unsigned os);
    int unsigned q;
    q = (clk_hz + (baud * os) / 2) / (baud * os);
    return (q == 0) ? 1 : q;
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Sample-tick generator: one-cycle tick every divisor clocks for the selected
// baud rate; the count restarts whenever baud_sel changes.
module uart_tick_gen
  import uart_p_pkg::*;
#(
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CLK_HZ     = 50000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_sel_i,
  output logic       tick_o
);

  localparam int unsigned DivTab [8] = '{
    div(CLK_HZ, BAUD_TABLE[0], OVERSAMPLE), div(CLK_HZ, BAUD_TABLE[1], OVERSAMPLE),
    div(CLK_HZ, BAUD_TABLE[2], OVERSAMPLE), div(CLK_HZ, BAUD_TABLE[3], OVERSAMPLE),
    div(CLK_HZ, BAUD_TABLE[4], OVERSAMPLE), div(CLK_HZ, BAUD_TABLE[5], OVERSAMPLE),
    div(CLK_HZ, BAUD_TABLE[6], OVERSAMPLE), div(CLK_HZ, BAUD_TABLE[7], OVERSAMPLE)
  };

  logic [31:0] cnt_q;
  logic [2:0]  sel_q;

  // Tick on the last count of the period, suppressed on the cycle the rate changes.
  always_comb begin
    tick_o = (baud_sel_i == sel_q) && (cnt_q == DivTab[baud_sel_i] - 32'd1);
  end

  // Divisor counter with restart on rate change.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      sel_q <= '0;
    end else begin
      sel_q <= baud_sel_i;
      if ((baud_sel_i != sel_q) || tick_o) cnt_q <= '0;
      else                                 cnt_q <= cnt_q + 32'd1;
    end
  end

endmodule

// File: rtl/uart_xcvr_p.sv
// Full-duplex UART transceiver with TX FIFO, runtime parity / stop-bit
// selection and a 16x-oversampled receiver with start-glitch rejection.
// Optional feature macro: UART_LOOPBACK_EN adds a loopback input port.
module uart_xcvr_p
  import uart_p_pkg::*;
#(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned OVERSAMPLE = 16,
  parameter int unsigned CLK_HZ     = 50000000,
  parameter int unsigned TXF_DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [2:0]        baud_sel,
  input  logic [1:0]        par_mode,
  input  logic              stop2,
  input  logic              tx_en,
  input  logic              tx_wr,
  input  logic [DATA_W-1:0] tx_data,
  output logic              tx_full,
  output logic              tx_busy,
  output logic              txd,
  input  logic              rx_en,
  input  logic              rxd,
  output logic [DATA_W-1:0] rx_data,
  output logic              rx_valid,
  output logic              rx_ferror,
  output logic              rx_perror
`ifdef UART_LOOPBACK_EN
  ,
  input  logic              loopback
`endif
);

  localparam int unsigned OsW  = $clog2(OVERSAMPLE);
  localparam int unsigned PtrW = $clog2(TXF_DEPTH);
  localparam int unsigned CntW = $clog2(TXF_DEPTH + 1);

  logic tick;

  uart_tick_gen #(
    .OVERSAMPLE(OVERSAMPLE),
    .CLK_HZ    (CLK_HZ)
  ) u_tick (
    .clk       (clk),
    .reset     (reset),
    .baud_sel_i(baud_sel),
    .tick_o    (tick)
  );

  // ---------------- TX FIFO ----------------
  logic [DATA_W-1:0] fifo_q [TXF_DEPTH];
  logic [PtrW-1:0]   wptr_q, rptr_q;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              full_q;
  logic              push, pop;

  // ---------------- TX FSM ----------------
  tx_state_e         tx_st_q;
  logic [OsW-1:0]    tx_cnt_q;
  logic [3:0]        tx_bit_q;
  logic [DATA_W-1:0] tx_sh_q, tx_word;
  logic              tx_par_q, tx_use_par_q, tx_stop2_q, txd_q;
  logic              tx_bit_end, tx_last;

  assign tx_word    = fifo_q[rptr_q];
  assign tx_bit_end = tick && (tx_cnt_q == OsW'(OVERSAMPLE - 1));
  assign tx_last    = tx_bit_end &&
                      (((tx_st_q == TxStop1) && !tx_stop2_q) || (tx_st_q == TxStop2));
  // Popping at the end of the last stop bit gives back-to-back frames.
  assign pop        = tx_en && (cnt_q != '0) && ((tx_st_q == TxIdle) || tx_last);
  assign push       = tx_wr && (!full_q || pop);

  // FIFO occupancy next-state.
  always_comb begin
    cnt_d = cnt_q;
    if (push && !pop)      cnt_d = cnt_q + 1'b1;
    else if (pop && !push) cnt_d = cnt_q - 1'b1;
  end

  // FIFO storage, no reset needed.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= tx_data;
  end

  // FIFO pointers, count and registered full flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      full_q <= 1'b0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == CntW'(TXF_DEPTH));
    end
  end

  // TX frame sequencer with registered serial output.
  always_ff @(posedge clk) begin
    if (reset) begin
      tx_st_q      <= TxIdle;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_sh_q      <= '0;
      tx_par_q     <= 1'b0;
      tx_use_par_q <= 1'b0;
      tx_stop2_q   <= 1'b0;
      txd_q        <= 1'b1;
    end else if (pop) begin
      tx_st_q      <= TxStart;
      tx_cnt_q     <= '0;
      tx_bit_q     <= '0;
      tx_sh_q      <= tx_word;
      tx_par_q     <= (par_mode == PAR_ODD) ? ~(^tx_word) : ^tx_word;
      tx_use_par_q <= (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
      tx_stop2_q   <= stop2;
      txd_q        <= 1'b0;
    end else if (tick && (tx_st_q != TxIdle)) begin
      if (!tx_bit_end) begin
        tx_cnt_q <= tx_cnt_q + 1'b1;
      end else begin
        tx_cnt_q <= '0;
        case (tx_st_q)
          TxStart: begin
            tx_st_q <= TxData;
            txd_q   <= tx_sh_q[0];
            tx_sh_q <= tx_sh_q >> 1;
          end
          TxData: begin
            if (tx_bit_q == 4'(DATA_W - 1)) begin
              tx_st_q <= tx_use_par_q ? TxParity : TxStop1;
              txd_q   <= tx_use_par_q ? tx_par_q : 1'b1;
            end else begin
              tx_bit_q <= tx_bit_q + 1'b1;
              txd_q    <= tx_sh_q[0];
              tx_sh_q  <= tx_sh_q >> 1;
            end
          end
          TxParity: begin
            tx_st_q <= TxStop1;
            txd_q   <= 1'b1;
          end
          TxStop1: tx_st_q <= tx_stop2_q ? TxStop2 : TxIdle;
          default: tx_st_q <= TxIdle;
        endcase
      end
    end
  end

  assign tx_full = full_q;
  assign tx_busy = (cnt_q != '0) || (tx_st_q != TxIdle);

  // ---------------- RX ----------------
  logic rx_in;
`ifdef UART_LOOPBACK_EN
  assign rx_in = loopback ? txd_q : rxd;
  assign txd   = loopback ? 1'b1 : txd_q;
`else
  assign rx_in = rxd;
  assign txd   = txd_q;
`endif

  logic [1:0]        sync_q;
  logic              rx_prev_q, rx_s, rx_fall;
  rx_state_e         rx_st_q;
  logic [OsW-1:0]    rx_cnt_q, rx_lim;
  logic [3:0]        rx_bit_q;
  logic [DATA_W-1:0] rx_sh_q, rx_data_q;
  logic              rx_perr_q, rx_ferr_q, rx_use_par_q, rx_odd_q, rx_stop2_q;
  logic              rx_valid_q, rx_fe_q, rx_pe_q, rx_fe_now;

  assign rx_s      = sync_q[1];
  assign rx_fall   = rx_prev_q && !rx_s;
  assign rx_lim    = (rx_st_q == RxStart) ? OsW'(OVERSAMPLE / 2 - 1) : OsW'(OVERSAMPLE - 1);
  assign rx_fe_now = rx_ferr_q | ~rx_s;

  // Two-flop synchroniser plus edge-detect history, idling high.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx_in};
      rx_prev_q <= rx_s;
    end
  end

  // RX frame sequencer: centre sampling, error capture and word delivery.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_st_q      <= RxIdle;
      rx_cnt_q     <= '0;
      rx_bit_q     <= '0;
      rx_sh_q      <= '0;
      rx_perr_q    <= 1'b0;
      rx_ferr_q    <= 1'b0;
      rx_use_par_q <= 1'b0;
      rx_odd_q     <= 1'b0;
      rx_stop2_q   <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      rx_fe_q      <= 1'b0;
      rx_pe_q      <= 1'b0;
    end else begin
      rx_valid_q <= 1'b0;
      if (!rx_en) begin
        rx_st_q  <= RxIdle;
        rx_cnt_q <= '0;
      end else begin
        case (rx_st_q)
          RxIdle: begin
            if (rx_fall) begin
              rx_st_q      <= RxStart;
              rx_cnt_q     <= '0;
              rx_bit_q     <= '0;
              rx_perr_q    <= 1'b0;
              rx_ferr_q    <= 1'b0;
              rx_use_par_q <= (par_mode == PAR_EVEN) || (par_mode == PAR_ODD);
              rx_odd_q     <= (par_mode == PAR_ODD);
              rx_stop2_q   <= stop2;
            end
          end
          RxBreak: if (rx_s) rx_st_q <= RxIdle;
          default: begin
            if (tick) begin
              if (rx_cnt_q != rx_lim) begin
                rx_cnt_q <= rx_cnt_q + 1'b1;
              end else begin
                rx_cnt_q <= '0;
                case (rx_st_q)
                  // A start bit that reads high at mid-bit was a glitch.
                  RxStart: rx_st_q <= rx_s ? RxIdle : RxData;
                  RxData: begin
                    rx_sh_q <= {rx_s, rx_sh_q[DATA_W-1:1]};
                    if (rx_bit_q == 4'(DATA_W - 1)) begin
                      rx_st_q <= rx_use_par_q ? RxParity : RxStop1;
                    end else begin
                      rx_bit_q <= rx_bit_q + 1'b1;
                    end
                  end
                  RxParity: begin
                    rx_perr_q <= rx_s ^ (^rx_sh_q) ^ rx_odd_q;
                    rx_st_q   <= RxStop1;
                  end
                  RxStop1: begin
                    if (rx_stop2_q) begin
                      rx_ferr_q <= ~rx_s;
                      rx_st_q   <= RxStop2;
                    end else begin
                      rx_data_q  <= rx_sh_q;
                      rx_fe_q    <= rx_fe_now;
                      rx_pe_q    <= rx_perr_q;
                      rx_valid_q <= 1'b1;
                      rx_st_q    <= rx_s ? RxIdle : RxBreak;
                    end
                  end
                  default: begin
                    rx_data_q  <= rx_sh_q;
                    rx_fe_q    <= rx_fe_now;
                    rx_pe_q    <= rx_perr_q;
                    rx_valid_q <= 1'b1;
                    rx_st_q    <= rx_s ? RxIdle : RxBreak;
                  end
                endcase
              end
            end
          end
        endcase
      end
    end
  end

  assign rx_data   = rx_data_q;
  assign rx_valid  = rx_valid_q;
  assign rx_ferror = rx_fe_q;
  assign rx_perror = rx_pe_q;

endmodule

// File: tb/tb_uart_xcvr_p.sv
// Scoreboard bench for uart_xcvr_p: directed scenarios plus random loopback
// frames, with independent TX-line and RX-word monitors.
`timescale 1ns/1ps
module tb_uart_xcvr_p;

  localparam int unsigned DW    = 8;
  localparam int unsigned OS    = 16;
  localparam int unsigned CLKHZ = 7372800;
  localparam int unsigned DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [2:0]    baud_sel = 3'd7;
  logic [1:0]    par_mode = 2'b00;
  logic          stop2 = 1'b0;
  logic          tx_en = 1'b0;
  logic          tx_wr = 1'b0;
  logic [DW-1:0] tx_data = '0;
  logic          rx_en = 1'b1;
  logic          rxd_drv = 1'b1;
  logic          lb_mode = 1'b0;
  wire           tx_full, tx_busy, txd, rx_valid, rx_ferror, rx_perror;
  wire  [DW-1:0] rx_data;
  wire           rxd = lb_mode ? txd : rxd_drv;

  uart_xcvr_p #(
    .DATA_W    (DW),
    .OVERSAMPLE(OS),
    .CLK_HZ    (CLKHZ),
    .TXF_DEPTH (DEPTH)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .baud_sel (baud_sel),
    .par_mode (par_mode),
    .stop2    (stop2),
    .tx_en    (tx_en),
    .tx_wr    (tx_wr),
    .tx_data  (tx_data),
    .tx_full  (tx_full),
    .tx_busy  (tx_busy),
    .txd      (txd),
    .rx_en    (rx_en),
    .rxd      (rxd),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ferror(rx_ferror),
    .rx_perror(rx_perror)
`ifdef UART_LOOPBACK_EN
    ,
    .loopback (1'b0)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {logic [DW-1:0] d; logic [1:0] pm; logic s2;} tx_exp_t;
  typedef struct {logic [DW-1:0] d; logic fe; logic pe;} rx_exp_t;

  tx_exp_t     tx_q[$];
  rx_exp_t     rx_q[$];
  int          n_chk = 0;
  int          n_fail = 0;
  int          tx_frames = 0;
  int unsigned bitc;
  bit          tx_abort = 0;
  logic        txd_prev = 1'b1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int unsigned bit_cycles(input logic [2:0] sel);
    int unsigned baud;
    case (sel)
      3'd0: baud = 300;    3'd1: baud = 1200;   3'd2: baud = 4800;  3'd3: baud = 9600;
      3'd4: baud = 19200;  3'd5: baud = 38400;  3'd6: baud = 57600; default: baud = 115200;
    endcase
    return OS * ((CLKHZ + baud * OS / 2) / (baud * OS));
  endfunction

  function automatic bit has_par(input logic [1:0] pm);
    return (pm == 2'b01) || (pm == 2'b10);
  endfunction

  function automatic logic par_bit(input logic [DW-1:0] d, input logic [1:0] pm);
    return (pm == 2'b10) ? ~(^d) : ^d;
  endfunction

  // TX line monitor: decodes each frame at bit centres and compares to the queue.
  always begin : tx_mon
    tx_exp_t       e;
    logic [DW-1:0] d;
    logic          st, pb, s1, s2b;
    bit            have;
    int unsigned   b;
    @(negedge clk);
    if (txd_prev && !txd) begin
      b    = bitc;
      have = (tx_q.size() != 0);
      if (have) e = tx_q.pop_front();
      else begin
        e.d = '0; e.pm = par_mode; e.s2 = stop2;
      end
      repeat (b / 2) @(negedge clk);
      st = txd;
      for (int i = 0; i < DW; i++) begin
        repeat (b) @(negedge clk);
        d[i] = txd;
      end
      pb = 1'b0;
      if (has_par(e.pm)) begin
        repeat (b) @(negedge clk);
        pb = txd;
      end
      repeat (b) @(negedge clk);
      s1  = txd;
      s2b = 1'b1;
      if (e.s2) begin
        repeat (b) @(negedge clk);
        s2b = txd;
      end
      if (!tx_abort) begin
        tx_frames++;
        chk("tx_frame_expected", int'(have), 1);
        chk("tx_start_bit", int'(st), 0);
        chk("tx_data_bits", int'(d), int'(e.d));
        if (has_par(e.pm)) chk("tx_parity_bit", int'(pb), int'(par_bit(e.d, e.pm)));
        chk("tx_stop1", int'(s1), 1);
        if (e.s2) chk("tx_stop2", int'(s2b), 1);
      end
    end
    txd_prev = txd;
  end

  // RX word monitor.
  always @(negedge clk) begin
    if (rx_valid) begin
      if (rx_q.size() == 0) begin
        chk("rx_unexpected_valid", 1, 0);
      end else begin
        rx_exp_t e;
        e = rx_q.pop_front();
        chk("rx_data", int'(rx_data), int'(e.d));
        chk("rx_ferror", int'(rx_ferror), int'(e.fe));
        chk("rx_perror", int'(rx_perror), int'(e.pe));
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] d, input bit expect_rx);
    @(posedge clk); #1;
    tx_wr   = 1'b1;
    tx_data = d;
    @(posedge clk); #1;
    tx_wr = 1'b0;
    tx_q.push_back(tx_exp_t'{d: d, pm: par_mode, s2: stop2});
    if (expect_rx) rx_q.push_back(rx_exp_t'{d: d, fe: 1'b0, pe: 1'b0});
  endtask

  task automatic drive_bit(input logic v);
    rxd_drv = v;
    repeat (bitc) @(posedge clk);
    #1;
  endtask

  task automatic send_rx(input logic [DW-1:0] d, input bit bad_par, input bit bad_stop,
                         input int unsigned hold_bits);
    rx_q.push_back(rx_exp_t'{d: d, fe: bad_stop, pe: bad_par && has_par(par_mode)});
    @(posedge clk); #1;
    drive_bit(1'b0);
    for (int i = 0; i < DW; i++) drive_bit(d[i]);
    if (has_par(par_mode)) drive_bit(par_bit(d, par_mode) ^ bad_par);
    drive_bit(!bad_stop);
    if (stop2) drive_bit(1'b1);
    if (hold_bits != 0) begin
      rxd_drv = 1'b0;
      repeat (hold_bits * bitc) @(posedge clk);
      #1;
    end
    rxd_drv = 1'b1;
    repeat (bitc) @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int unsigned n = 0;
    int unsigned lim = 16 * 12 * bitc;
    while ((tx_busy || tx_q.size() != 0 || rx_q.size() != 0) && n < lim) begin
      @(negedge clk);
      n++;
    end
    chk("idle_within_budget", int'(n < lim), 1);
    repeat (bitc) @(negedge clk);
  endtask

  initial begin
    int          f0;
    int unsigned n;
    int          model_cnt;
    bitc = bit_cycles(baud_sel);

    // Reset values while reset is held.
    repeat (3) @(posedge clk);
    #1;
    chk("reset_txd", int'(txd), 1);
    chk("reset_tx_busy", int'(tx_busy), 0);
    chk("reset_tx_full", int'(tx_full), 0);
    chk("reset_rx_valid", int'(rx_valid), 0);
    chk("reset_rx_data", int'(rx_data), 0);
    chk("reset_rx_flags", int'({rx_ferror, rx_perror}), 0);
    reset = 1'b0;
    repeat (4) @(posedge clk);
    #1;

    // 115200 8N1 through the external loop.
    lb_mode = 1'b1;
    tx_en   = 1'b1;
    push_word(8'hA5, 1'b1);
    wait_idle();

    // Even parity on TX, then a receive with a wrong parity bit.
    par_mode = 2'b01;
    push_word(8'h07, 1'b1);
    wait_idle();
    lb_mode = 1'b0;
    send_rx(8'h07, 1'b1, 1'b0, 0);
    wait_idle();

    // Framing error with the line held low afterwards, then a clean frame.
    par_mode = 2'b00;
    send_rx(8'h5A, 1'b0, 1'b1, 3);
    send_rx(8'h81, 1'b0, 1'b0, 0);
    wait_idle();

    // Short start glitch must be ignored; the next frame must still arrive.
    @(posedge clk); #1;
    rxd_drv = 1'b0;
    repeat (3 * (bitc / OS)) @(posedge clk);
    #1;
    rxd_drv = 1'b1;
    repeat (2 * bitc) @(posedge clk);
    #1;
    send_rx(8'h3C, 1'b0, 1'b0, 0);
    wait_idle();

    // FIFO fill with transmitter disabled, overflow drop, then drain.
    lb_mode   = 1'b1;
    tx_en     = 1'b0;
    model_cnt = 0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      tx_wr   = 1'b1;
      tx_data = DW'(i);
      @(posedge clk); #1;
      tx_wr = 1'b0;
      if (model_cnt < DEPTH) begin
        model_cnt++;
        tx_q.push_back(tx_exp_t'{d: DW'(i), pm: par_mode, s2: stop2});
        rx_q.push_back(rx_exp_t'{d: DW'(i), fe: 1'b0, pe: 1'b0});
      end
      chk("fifo_full_flag", int'(tx_full), int'(model_cnt == DEPTH));
    end
    repeat (3 * bitc) @(posedge clk);
    chk("tx_idle_while_disabled", int'(txd), 1);
    #1;
    f0    = tx_frames;
    tx_en = 1'b1;
    n     = 0;
    while (tx_busy && n < 6 * 12 * bitc) begin
      @(negedge clk);
      n++;
    end
    chk("busy_fall_budget", int'(n < 6 * 12 * bitc), 1);
    chk("frames_before_busy_fall", tx_frames - f0, 4);
    wait_idle();

    // Random loopback frames under random configurations.
    for (int c = 0; c < 4; c++) begin
      baud_sel = 3'($urandom_range(5, 7));
      par_mode = 2'($urandom_range(0, 3));
      stop2    = 1'($urandom_range(0, 1));
      bitc     = bit_cycles(baud_sel);
      repeat (4) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
        n = 0;
        while (tx_full && n < 20 * bitc) begin
          @(posedge clk); #1;
          n++;
        end
        push_word(DW'($urandom), 1'b1);
      end
      wait_idle();
    end

    // Reset in the middle of a data bit.
    baud_sel = 3'd7;
    par_mode = 2'b00;
    stop2    = 1'b0;
    bitc     = bit_cycles(baud_sel);
    repeat (4) @(posedge clk);
    #1;
    push_word(8'h96, 1'b1);
    repeat (4 * bitc) @(posedge clk);
    #1;
    tx_abort = 1;
    reset    = 1'b1;
    @(posedge clk); #1;
    chk("midreset_txd", int'(txd), 1);
    chk("midreset_tx_busy", int'(tx_busy), 0);
    chk("midreset_tx_full", int'(tx_full), 0);
    chk("midreset_rx_data", int'(rx_data), 0);
    reset = 1'b0;
    tx_q.delete();
    rx_q.delete();
    repeat (14 * bitc) @(posedge clk);
    #1;
    tx_abort = 0;
    push_word(8'h5C, 1'b1);
    wait_idle();

    chk("tx_queue_drained", tx_q.size(), 0);
    chk("rx_queue_drained", rx_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
